// File: rtl/pulse_frame_sched.sv
// pulse_frame_sched: round-robin scheduler that grants one requester at a time
// and drives that requester's frame onto a shared x/y pulse bus.
//
// A frame is one x pulse, then N y pulses (N = the winner's 2-bit count), then
// one x pulse. The frame's last cycle carries done. At least GAP_CYC quiet
// cycles separate consecutive frames.
//
// Ports
//   clk     : clock; all state changes on the rising edge
//   reset   : asynchronous, active-high reset
//   req_i   : [NUM_REQ] level-sensitive frame requests
//   ycnt_i  : [2*NUM_REQ] per-requester y count; slice [2i+1:2i] is requester i
//   x_o     : shared x event pulse
//   y_o     : shared y event pulse
//   gnt_o   : [NUM_REQ] one-hot grant, held from the head x through the tail x
//   done_o  : one-cycle pulse on the last cycle of a frame
//   busy_o  : high whenever the scheduler is not idle
//
// Every output is a flop. Its D input comes from the next-state decode, so no
// path exists from req_i or ycnt_i to an output within a cycle.
module pulse_frame_sched #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned GAP_CYC = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NUM_REQ-1:0]     req_i,
  input  logic [2*NUM_REQ-1:0]   ycnt_i,
  output logic                   x_o,
  output logic                   y_o,
  output logic [NUM_REQ-1:0]     gnt_o,
  output logic                   done_o,
  output logic                   busy_o
);

  localparam int unsigned PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned CNT_W = 2;
  localparam int unsigned GAP_W = 4;

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_X_HEAD  = 3'd1;
  localparam logic [2:0] S_Y_BURST = 3'd2;
  localparam logic [2:0] S_X_TAIL  = 3'd3;
  localparam logic [2:0] S_GAP     = 3'd4;

  logic [2:0]         state_q;
  logic [2:0]         state_d;
  logic [PTR_W-1:0]   ptr_q;
  logic [PTR_W-1:0]   ptr_d;
  logic [CNT_W-1:0]   cnt_q;
  logic [CNT_W-1:0]   cnt_d;
  logic [GAP_W-1:0]   gap_q;
  logic [GAP_W-1:0]   gap_d;
  logic [NUM_REQ-1:0] gnt_d;
  logic               x_d;
  logic               y_d;
  logic               done_d;
  logic               busy_d;
  logic               take_grant;

  logic               arb_found;
  logic [PTR_W-1:0]   arb_win;
  int unsigned        arb_idx;
  logic [CNT_W-1:0]   ycnt_slice [NUM_REQ];

  // Split the packed count bus into one entry per requester.
  for (genvar g = 0; g < NUM_REQ; g++) begin : g_slice
    assign ycnt_slice[g] = ycnt_i[2*g +: 2];
  end

  // Round-robin search.
  // It starts at the priority pointer, wraps past NUM_REQ-1, and stops at the
  // first requester found.
  always_comb begin
    arb_found = 1'b0;
    arb_win   = '0;
    arb_idx   = 0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      arb_idx = 32'(ptr_q) + i;
      if (arb_idx >= NUM_REQ) begin
        arb_idx = arb_idx - NUM_REQ;
      end
      if (!arb_found && req_i[PTR_W'(arb_idx)]) begin
        arb_found = 1'b1;
        arb_win   = PTR_W'(arb_idx);
      end
    end
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and next-output decode.
  // A grant is taken at three points:
  //   - from IDLE;
  //   - on the edge that ends the last gap cycle;
  //   - on the edge that ends the tail when there is no gap.
  // This keeps consecutive frames exactly GAP_CYC cycles apart while requests
  // are pending.
  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    cnt_d      = cnt_q;
    gap_d      = gap_q;
    gnt_d      = gnt_o;
    take_grant = 1'b0;

    case (state_q)
      S_IDLE: begin
        gnt_d      = '0;
        take_grant = arb_found;
      end
      S_X_HEAD: begin
        state_d = (cnt_q != '0) ? S_Y_BURST : S_X_TAIL;
      end
      S_Y_BURST: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q <= CNT_W'(1)) begin
          state_d = S_X_TAIL;
        end
      end
      S_X_TAIL: begin
        gnt_d = '0;
        if (GAP_CYC != 0) begin
          state_d = S_GAP;
          gap_d   = GAP_W'(GAP_CYC);
        end else begin
          state_d    = S_IDLE;
          take_grant = arb_found;
        end
      end
      S_GAP: begin
        gnt_d = '0;
        gap_d = gap_q - GAP_W'(1);
        if (gap_q <= GAP_W'(1)) begin
          state_d    = S_IDLE;
          take_grant = arb_found;
        end
      end
      default: begin
        state_d = S_IDLE;
        gnt_d   = '0;
      end
    endcase

    // The count and grant are latched here only.
    // Later changes to req_i or ycnt_i cannot affect a running frame.
    if (take_grant) begin
      state_d = S_X_HEAD;
      cnt_d   = ycnt_slice[arb_win];
      gnt_d   = NUM_REQ'(1) << arb_win;
      ptr_d   = (arb_win == PTR_W'(NUM_REQ - 1)) ? '0 : arb_win + PTR_W'(1);
    end

    x_d    = (state_d == S_X_HEAD) || (state_d == S_X_TAIL);
    y_d    = (state_d == S_Y_BURST);
    done_d = (state_d == S_X_TAIL);
    busy_d = (state_d != S_IDLE);
  end

  // Frame datapath: priority pointer, y countdown, gap countdown.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr_q <= '0;
      cnt_q <= '0;
      gap_q <= '0;
    end else begin
      ptr_q <= ptr_d;
      cnt_q <= cnt_d;
      gap_q <= gap_d;
    end
  end

  // Output flops; reset clears them immediately.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      x_o    <= 1'b0;
      y_o    <= 1'b0;
      done_o <= 1'b0;
      busy_o <= 1'b0;
      gnt_o  <= '0;
    end else begin
      x_o    <= x_d;
      y_o    <= y_d;
      done_o <= done_d;
      busy_o <= busy_d;
      gnt_o  <= gnt_d;
    end
  end

  // Bus invariants.
  a_xy_excl : assert property (@(posedge clk) disable iff (reset) !(x_o && y_o));
  a_gnt_oh  : assert property (@(posedge clk) disable iff (reset) $onehot0(gnt_o));
  a_gnt_bsy : assert property (@(posedge clk) disable iff (reset) (gnt_o != '0) |-> busy_o);
  a_done_x  : assert property (@(posedge clk) disable iff (reset) done_o |-> x_o);

endmodule

// File: doc/pulse_frame_sched.md
PULSE_FRAME_SCHED -- requirements
Module: pulse_frame_sched

Interface
REQ-001 Parameter NUM_REQ, default 4, is the number of requesters sharing the pulse bus (2..8).
REQ-002 Parameter GAP_CYC, default 2, is the number of idle cycles forced between frames (0..15).
REQ-003 clk  input  1  clock, all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 req_i  input  NUM_REQ  per-requester frame request, level-sensitive.
REQ-006 ycnt_i  input  2*NUM_REQ  per-requester y-pulse count; slice [2i+1:2i] belongs to requester i, range 0..3.
REQ-007 x_o  output  1  shared x event pulse to the downstream pulse detector.
REQ-008 y_o  output  1  shared y event pulse to the downstream pulse detector.
REQ-009 gnt_o  output  NUM_REQ  one-hot grant, held for the whole frame.
REQ-010 done_o  output  1  one-cycle pulse marking the last cycle of a frame.
REQ-011 busy_o  output  1  high in every state except IDLE.

Function
REQ-012 FSM states SHALL be exactly IDLE, X_HEAD, Y_BURST, X_TAIL and GAP.
REQ-013 A frame SHALL be x_o for 1 cycle, then y_o for N consecutive cycles (N = winner's ycnt), then x_o for 1 cycle; total length N+2 cycles.
REQ-014 IDLE: when any req_i bit is high at a rising edge, the FSM SHALL select a winner, latch its ycnt slice and go to X_HEAD; x_o is high the cycle after req_i is first sampled high.
REQ-015 Arbitration SHALL be round-robin: search starts at the priority pointer and wraps from NUM_REQ-1 to 0; the pointer becomes winner+1 (mod NUM_REQ) on grant.
REQ-016 X_HEAD: x_o=1; next state Y_BURST if latched count > 0, else X_TAIL.
REQ-017 Y_BURST: y_o=1 every cycle; the count decrements each cycle; leave for X_TAIL in the cycle the count reaches 1.
REQ-018 X_TAIL: x_o=1 and done_o=1; next state GAP if GAP_CYC > 0, else IDLE.
REQ-019 GAP: all pulse outputs are 0 for exactly GAP_CYC cycles, then IDLE; requests are not arbitrated during GAP.
REQ-020 x_o and y_o SHALL never be high in the same cycle.
REQ-021 gnt_o SHALL be the winner's one-hot from X_HEAD through X_TAIL inclusive, and all-zero otherwise.
REQ-022 ycnt_i and req_i SHALL be sampled only at grant; later changes, including req_i deassertion mid-frame, SHALL NOT alter or abort the frame.
REQ-023 A requester still holding req_i after its done_o competes again with lowest priority.
REQ-024 If multiple requests arrive simultaneously, exactly one grant SHALL be issued per frame, and no requester SHALL wait more than NUM_REQ-1 frames.
REQ-025 The ycnt value 0 is legal and yields a back-to-back x_o, x_o frame of 2 cycles.
REQ-026 All outputs SHALL be registered or decoded from registered state only, with no combinational path from req_i or ycnt_i.

Reset
REQ-027 On reset assertion: state=IDLE, priority pointer=0, count=0, gap counter=0; x_o, y_o, done_o, busy_o=0 and gnt_o=0 immediately, without waiting for a clock.
REQ-028 Reset asserted mid-frame SHALL abort the frame with no further pulses; after release, the first grant searches from requester 0.

Verification
REQ-029 Single request: req_i=0001, ycnt0=2, GAP_CYC=2. Required: x_o at T+1; y_o at T+2 and T+3; x_o+done_o at T+4; busy_o low from T+7.
REQ-030 Zero count: req_i=0100, ycnt2=0. Required: x_o at T+1 and T+2; y_o never high; gnt_o=0100 for 2 cycles.
REQ-031 Round-robin: req_i=1111 held, all ycnt=1. Required: grant order 0,1,2,3,0; each frame 3 cycles with GAP_CYC idle cycles between frames.
REQ-032 Mid-frame changes: req_i drops and ycnt changes during Y_BURST. Required: the frame completes with the originally latched count.
REQ-033 Reset during Y_BURST. Required: all outputs 0 asynchronously; with req_i=1010 after release, requester 1 is granted first.
REQ-034 GAP_CYC=0 with req_i=0011 held. Required: the next x_o head follows done_o with no idle cycle between frames.
